// File: rtl/tx_if.sv
// Byte-stream handshake between a frame source and the transmitter.
// The source drives a byte plus framing info; the transmitter answers with ready.
interface tx_if;
  logic [7:0] data;
  logic [2:0] data_bits;
  logic       last;
  logic       valid;
  logic       ready;

  modport master (output data, data_bits, last, valid, input ready);
  modport slave  (input data, data_bits, last, valid, output ready);
endinterface

// File: rtl/tx.sv
// Card-to-reader transmitter: frames bytes as SOC, Manchester data bits, odd parity, EOC,
// and drives a subcarrier-modulated load-modulation output.
module tx #(
  parameter int BIT_CLKS = 128,
  parameter int SC_CLKS  = 16
) (
  input  logic clk,
  input  logic rst_n,
  tx_if.slave  byteIf,
  output logic lm_out,
  output logic busy,
  output logic underflow
);

  localparam int CW   = $clog2(BIT_CLKS);
  localparam int SW   = $clog2(SC_CLKS);
  localparam int HALF = BIT_CLKS / 2;

  typedef enum logic [2:0] {IDLE, SOC, DATA, PARITY, EOC} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   bitCnt_q, bitCnt_d;
  logic [SW-1:0]   scCnt_q, scCnt_d;
  logic [2:0]      bitIdx_q, bitIdx_d;
  logic [2:0]      lastIdx_q, lastIdx_d;
  logic [7:0]      byte_q, byte_d;
  logic            last_q, last_d;
  logic            bitVal_q, bitVal_d;
  logic            acc_q, acc_d;
  logic            ready_q, ready_d;
  logic            lm_q, lm_d;
  logic            busy_q, busy_d;
  logic            uf_q, uf_d;

  logic            accept;
  logic            lastCyc;
  logic            scWrap;
  logic            inFrame;
  logic            firstHalf;

  assign accept  = byteIf.valid && ready_q;
  assign lastCyc = (bitCnt_q == CW'(BIT_CLKS - 1));
  assign scWrap  = (scCnt_q == SW'(SC_CLKS - 1));

  assign byteIf.ready = ready_q;
  assign lm_out       = lm_q;
  assign busy         = busy_q;
  assign underflow    = uf_q;

  always_comb begin
    state_d   = state_q;
    bitIdx_d  = bitIdx_q;
    lastIdx_d = lastIdx_q;
    byte_d    = byte_q;
    last_d    = last_q;
    bitVal_d  = bitVal_q;
    acc_d     = acc_q;
    ready_d   = ready_q;
    uf_d      = 1'b0;
    bitCnt_d  = (state_q == IDLE || lastCyc) ? '0 : bitCnt_q + 1'b1;
    scCnt_d   = (state_q == IDLE || lastCyc || scWrap) ? '0 : scCnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          byte_d    = byteIf.data;
          last_d    = byteIf.last;
          lastIdx_d = (byteIf.last && byteIf.data_bits != 3'd0) ? byteIf.data_bits - 3'd1 : 3'd7;
          state_d   = SOC;
          bitVal_d  = 1'b1;
          ready_d   = 1'b0;
        end
      end
      SOC: begin
        if (lastCyc) begin
          state_d  = DATA;
          bitIdx_d = 3'd0;
          bitVal_d = byte_q[0];
        end
      end
      DATA: begin
        if (lastCyc) begin
          if (bitIdx_q != lastIdx_q) begin
            bitIdx_d = bitIdx_q + 3'd1;
            bitVal_d = byte_q[bitIdx_q + 3'd1];
          end else if (lastIdx_q == 3'd7) begin
            state_d  = PARITY;
            bitVal_d = ~^byte_q;
            ready_d  = !last_q;
          end else begin
            state_d  = EOC;
            bitVal_d = 1'b0;
          end
        end
      end
      PARITY: begin
        // The parity value lives in bitVal_q, so the byte registers can take the successor now.
        if (accept) begin
          byte_d    = byteIf.data;
          last_d    = byteIf.last;
          lastIdx_d = (byteIf.last && byteIf.data_bits != 3'd0) ? byteIf.data_bits - 3'd1 : 3'd7;
          acc_d     = 1'b1;
          ready_d   = 1'b0;
        end
        if (lastCyc) begin
          ready_d = 1'b0;
          acc_d   = 1'b0;
          if (acc_q || accept) begin
            state_d  = DATA;
            bitIdx_d = 3'd0;
            bitVal_d = byte_d[0];
          end else begin
            state_d  = EOC;
            bitVal_d = 1'b0;
            uf_d     = !last_q;
          end
        end
      end
      EOC: begin
        if (lastCyc) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A logic 1 modulates the first half-bit, a logic 0 the second half-bit.
    inFrame   = (state_d == SOC) || (state_d == DATA) || (state_d == PARITY);
    firstHalf = (bitCnt_d < CW'(HALF));
    lm_d      = inFrame && (firstHalf == bitVal_d) && (scCnt_d < SW'(SC_CLKS / 2));
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      scCnt_q   <= '0;
      bitIdx_q  <= 3'd0;
      lastIdx_q <= 3'd7;
      byte_q    <= 8'd0;
      last_q    <= 1'b0;
      bitVal_q  <= 1'b0;
      acc_q     <= 1'b0;
      ready_q   <= 1'b1;
      lm_q      <= 1'b0;
      busy_q    <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      scCnt_q   <= scCnt_d;
      bitIdx_q  <= bitIdx_d;
      lastIdx_q <= lastIdx_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      bitVal_q  <= bitVal_d;
      acc_q     <= acc_d;
      ready_q   <= ready_d;
      lm_q      <= lm_d;
      busy_q    <= busy_d;
      uf_q      <= uf_d;
    end
  end

endmodule

// File: tb/tb_tx.sv
// Self-checking bench for tx: fixed frame vectors, a mid-frame reset, and random frames
// compared against a bit-level frame model and a Manchester/subcarrier decoder.
module tb_tx;
  localparam int BC      = 128;
  localparam int SC      = 16;
  localparam int HALF    = BC / 2;
  localparam int TIMEOUT = 80 * BC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lmOut, busy, underflow;

  tx_if bus ();

  tx #(.BIT_CLKS(BC), .SC_CLKS(SC)) dut (
    .clk(clk), .rst_n(rst_n), .byteIf(bus),
    .lm_out(lmOut), .busy(busy), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic [7:0] data;
    logic [2:0] bits;
    logic       last;
    int         dly;
    bit         supply;
  } byteRec_t;

  typedef struct {
    byteRec_t    b0;
    byteRec_t    b1;
    bit          two;
    int          expPeriods;
    logic [31:0] expBits;
    int          expLen;
    int          expUf;
  } vec_t;

  byteRec_t frameQ[$];
  int       expQ[$];
  int       decQ[$];
  logic     lmQ[$];
  int       expBusy, expReady, expUf;
  int       gotBusy, gotReady, gotUf;
  vec_t     vecs[7];

  task automatic checkOutput(input string name, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic byteRec_t rec(input logic [7:0] d, input logic [2:0] b, input logic l,
                                   input int dly);
    byteRec_t r;
    r.data = d; r.bits = b; r.last = l; r.dly = dly; r.supply = 1'b1;
    return r;
  endfunction

  // Frame model: SOC 1, data bits LSB first, odd parity after full bytes, 2 marks EOC.
  task automatic buildModel();
    expQ.delete();
    expUf = 0;
    expReady = 0;
    expQ.push_back(1);
    for (int i = 0; i < frameQ.size(); i++) begin
      int n;
      n = (frameQ[i].last && frameQ[i].bits != 3'd0) ? int'(frameQ[i].bits) : 8;
      for (int k = 0; k < n; k++) expQ.push_back(int'(frameQ[i].data[k]));
      if (n == 8) expQ.push_back(int'(~^frameQ[i].data));
      if (frameQ[i].last) break;
      if (i + 1 < frameQ.size() && frameQ[i + 1].supply) begin
        expReady += frameQ[i + 1].dly + 1;
      end else begin
        expReady += BC;
        expUf = 1;
        break;
      end
    end
    expBusy = BC * (expQ.size() + 1);
    expQ.push_back(2);
  endtask

  function automatic int halfKind(input int base);
    bit allZero = 1'b1;
    bit isSc = 1'b1;
    for (int k = 0; k < HALF; k++) begin
      if (lmQ[base + k] !== 1'b0) allZero = 1'b0;
      if (lmQ[base + k] !== ((k % SC) < SC / 2)) isSc = 1'b0;
    end
    return allZero ? 0 : (isSc ? 1 : 3);
  endfunction

  function automatic int firstDiff(input int a[$], input int b[$]);
    int n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
    return (a.size() == b.size()) ? -1 : n;
  endfunction

  // Drives the queued frame, feeding successor bytes after their chosen delay into PARITY.
  task automatic applyStimulus();
    int  cyc = 0;
    int  nextIdx = 1;
    int  waitCnt = 0;
    bit  started = 1'b0;
    bit  done = 1'b0;
    gotBusy = 0; gotReady = 0; gotUf = 0;
    lmQ.delete();
    @(negedge clk);
    bus.data = frameQ[0].data; bus.data_bits = frameQ[0].bits;
    bus.last = frameQ[0].last; bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    while (!done && cyc < TIMEOUT) begin
      if (busy) begin
        started = 1'b1;
        gotBusy++;
        lmQ.push_back(lmOut);
        if (bus.ready) gotReady++;
      end
      if (underflow) gotUf++;
      if (started && !busy) begin
        done = 1'b1;
      end else begin
        bus.valid = 1'b0;
        bus.data = 8'($urandom); bus.data_bits = 3'($urandom); bus.last = 1'($urandom);
        if (!bus.ready) begin
          waitCnt = 0;
          bus.valid = 1'($urandom);
        end else if (nextIdx < frameQ.size() && frameQ[nextIdx].supply) begin
          if (waitCnt == frameQ[nextIdx].dly) begin
            bus.data = frameQ[nextIdx].data; bus.data_bits = frameQ[nextIdx].bits;
            bus.last = frameQ[nextIdx].last; bus.valid = 1'b1;
            nextIdx++;
          end
          waitCnt++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.valid = 1'b0;
    checkOutput("frameDone", done, 1);
    if (done) checkOutput("readyAfterEoc", bus.ready, 1);
  endtask

  task automatic analyse();
    decQ.delete();
    for (int p = 0; p < gotBusy / BC; p++) begin
      int h1 = halfKind(p * BC);
      int h2 = halfKind(p * BC + HALF);
      if (h1 == 1 && h2 == 0)      decQ.push_back(1);
      else if (h1 == 0 && h2 == 1) decQ.push_back(0);
      else if (h1 == 0 && h2 == 0) decQ.push_back(2);
      else                         decQ.push_back(3);
    end
    checkOutput("busyLen", gotBusy, expBusy);
    checkOutput("bitSeqDiffAt", firstDiff(decQ, expQ), -1);
    checkOutput("readyCycles", gotReady, expReady);
    checkOutput("underflowPulses", gotUf, expUf);
  endtask

  task automatic runVec(input int v);
    int handQ[$];
    frameQ.delete();
    frameQ.push_back(vecs[v].b0);
    if (vecs[v].two) frameQ.push_back(vecs[v].b1);
    buildModel();
    applyStimulus();
    analyse();
    for (int i = 0; i < vecs[v].expLen; i++) handQ.push_back(int'(vecs[v].expBits[i]));
    handQ.push_back(2);
    checkOutput($sformatf("vec%0d.busy", v), gotBusy, vecs[v].expPeriods * BC);
    checkOutput($sformatf("vec%0d.bitsDiffAt", v), firstDiff(decQ, handQ), -1);
    checkOutput($sformatf("vec%0d.underflow", v), gotUf, vecs[v].expUf);
  endtask

  initial begin
    bus.valid = 1'b0; bus.data = 8'd0; bus.data_bits = 3'd0; bus.last = 1'b0;
    vecs[0] = '{rec(8'h26, 3'd7, 1, 0), rec(8'h00, 3'd0, 1, 0), 0,  9, 32'h004D,  8, 0};
    vecs[1] = '{rec(8'h93, 3'd0, 1, 0), rec(8'h00, 3'd0, 1, 0), 0, 11, 32'h0327, 10, 0};
    vecs[2] = '{rec(8'h93, 3'd3, 0, 0), rec(8'h20, 3'd0, 1, 5), 1, 20, 32'h8327, 19, 0};
    vecs[3] = '{rec(8'h93, 3'd0, 0, 0), rec(8'h00, 3'd0, 1, 0), 0, 11, 32'h0327, 10, 1};
    vecs[4] = '{rec(8'h01, 3'd1, 1, 0), rec(8'h00, 3'd0, 1, 0), 0,  3, 32'h0003,  2, 0};
    vecs[5] = '{rec(8'h93, 3'd0, 0, 0), rec(8'h01, 3'd1, 1, BC - 1), 1, 12, 32'h0727, 11, 0};
    vecs[6] = '{rec(8'hFF, 3'd0, 1, 0), rec(8'h00, 3'd0, 1, 0), 0, 11, 32'h03FF, 10, 0};

    repeat (3) @(negedge clk);
    checkOutput("resetLm", lmOut, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetReady", bus.ready, 1);
    checkOutput("resetUnderflow", underflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) runVec(v);

    // Abort 0x93 in the modulated second half of data bit 3, then a clean frame must follow.
    @(negedge clk);
    bus.data = 8'h93; bus.data_bits = 3'd0; bus.last = 1'b1; bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (4 * BC + HALF + 2) @(negedge clk);
    checkOutput("preResetLm", lmOut, 1);
    checkOutput("preResetBusy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abortLm", lmOut, 0);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortReady", bus.ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    runVec(0);

    for (int f = 0; f < 8; f++) begin
      int n = int'($urandom_range(1, 3));
      frameQ.delete();
      for (int i = 0; i < n; i++) begin
        byteRec_t r;
        r.data = 8'($urandom);
        r.bits = 3'($urandom);
        r.last = (i == n - 1);
        r.dly = int'($urandom_range(0, BC - 1));
        r.supply = (i == 0) || ($urandom_range(0, 7) != 0);
        frameQ.push_back(r);
      end
      buildModel();
      applyStimulus();
      analyse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
